// File: rtl/uart_loader_if.sv
// rtl/uart_loader_if.sv - receive FIFO, transmit FIFO, instruction memory and CPU control bundle for uart_loader
// Purpose: groups every non-clock, non-reset signal of uart_loader.
// Ports (master = loader side, slave = FIFOs / memory / CPU side):
//   rd_empty, r_data, rd   : receive FIFO (first-word fall-through) pop interface
//   wr_full, wr, w_data    : transmit FIFO push interface
//   imem_we/addr/wdata     : instruction memory write port
//   cpu_start, busy        : CPU start strobe and loader status
interface uart_loader_if #(
  parameter int unsigned ADDR_W = 10
);
  logic              rd_empty;
  logic [7:0]        r_data;
  logic              rd;
  logic              wr_full;
  logic              wr;
  logic [7:0]        w_data;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_start;
  logic              busy;

  modport master (
    input  rd_empty, r_data, wr_full,
    output rd, wr, w_data, imem_we, imem_addr, imem_wdata, cpu_start, busy
  );

  modport slave (
    output rd_empty, r_data, wr_full,
    input  rd, wr, w_data, imem_we, imem_addr, imem_wdata, cpu_start, busy
  );
endinterface

// File: rtl/uart_loader.sv
// rtl/uart_loader.sv - UART command parser and program loader
// Purpose: pops command bytes from the receive FIFO, loads little-endian
// 32-bit words into instruction memory from address 0, pulses a CPU start
// strobe and answers every command with an ACK or NAK byte.
// Ports:
//   clk   : system clock
//   reset : asynchronous active-low reset
//   bus   : uart_loader_if.master (receive FIFO, transmit FIFO, imem, cpu_start, busy)
module uart_loader #(
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned TIMEOUT  = 50000,
  parameter logic [7:0]  ACK_BYTE = 8'h06,
  parameter logic [7:0]  NAK_BYTE = 8'h15
) (
  input logic           clk,
  input logic           reset,
  uart_loader_if.master bus
);
  localparam logic [7:0]  CMD_LOAD = 8'hA5;
  localparam logic [7:0]  CMD_RUN  = 8'h5A;
  localparam int unsigned DEPTH    = 32'd1 << ADDR_W;
  localparam int unsigned TMO_W    = $clog2(TIMEOUT + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_CNT_LO, S_CNT_HI, S_CHECK, S_PAYLOAD, S_WRITE, S_RUN, S_ACK, S_NAK
  } state_t;

  state_t            state_q, state_d;
  logic [15:0]       cnt_q, cnt_d;
  // One bit wider than the address so a full-depth load can count past the last word.
  logic [ADDR_W:0]   idx_q, idx_d;
  logic [1:0]        bidx_q, bidx_d;
  logic [31:0]       word_q, word_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [7:0]        w_data_q, w_data_d;
  logic              pop, push;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    bidx_d   = bidx_q;
    word_d   = word_q;
    tmo_d    = tmo_q;
    w_data_d = w_data_q;
    push     = 1'b0;
    pop      = (state_q inside {S_IDLE, S_CNT_LO, S_CNT_HI, S_PAYLOAD}) && !bus.rd_empty;

    if (pop) tmo_d = '0;

    case (state_q)
      S_IDLE: begin
        if (pop) begin
          if (bus.r_data == CMD_LOAD)     state_d = S_CNT_LO;
          else if (bus.r_data == CMD_RUN) state_d = S_RUN;
          else                            state_d = S_NAK;
        end
      end
      S_CNT_LO: begin
        if (pop) begin
          cnt_d   = {cnt_q[15:8], bus.r_data};
          state_d = S_CNT_HI;
        end
      end
      S_CNT_HI: begin
        if (pop) begin
          cnt_d   = {bus.r_data, cnt_q[7:0]};
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        tmo_d = '0;
        if (cnt_q == 16'd0)             state_d = S_ACK;
        else if (32'(cnt_q) > DEPTH)    state_d = S_NAK;
        else begin
          idx_d   = '0;
          bidx_d  = '0;
          state_d = S_PAYLOAD;
        end
      end
      S_PAYLOAD: begin
        if (pop) begin
          word_d[8*bidx_q +: 8] = bus.r_data;
          bidx_d                = bidx_q + 2'd1;
          if (bidx_q == 2'd3) state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        idx_d = idx_q + 1'b1;
        if (32'(idx_q) + 32'd1 == 32'(cnt_q)) state_d = S_ACK;
        else                                  state_d = S_PAYLOAD;
      end
      S_RUN: state_d = S_ACK;
      S_ACK, S_NAK: begin
        if (!bus.wr_full) begin
          push    = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Inter-byte watchdog: only armed while a command is mid-stream.
    if ((state_q inside {S_CNT_LO, S_CNT_HI, S_PAYLOAD}) && !pop) begin
      if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
        tmo_d   = '0;
        state_d = S_NAK;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end

    // Reply byte is latched on entry so it is stable while waiting on a full
    // transmit FIFO and keeps its value after the push.
    if (state_d == S_ACK && state_q != S_ACK) w_data_d = ACK_BYTE;
    if (state_d == S_NAK && state_q != S_NAK) w_data_d = NAK_BYTE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      bidx_q   <= '0;
      word_q   <= '0;
      tmo_q    <= '0;
      w_data_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      bidx_q   <= bidx_d;
      word_q   <= word_d;
      tmo_q    <= tmo_d;
      w_data_q <= w_data_d;
    end
  end

  // rd is combinational on the FIFO flag, so it is masked while reset is held.
  assign bus.rd         = pop & reset;
  assign bus.wr         = push;
  assign bus.w_data     = w_data_q;
  assign bus.imem_we    = (state_q == S_WRITE);
  assign bus.imem_addr  = idx_q[ADDR_W-1:0];
  assign bus.imem_wdata = word_q;
  assign bus.cpu_start  = (state_q == S_RUN);
  assign bus.busy       = (state_q != S_IDLE);
endmodule

// File: tb/tb_uart_loader.sv
// tb/tb_uart_loader.sv - directed vector bench for uart_loader
module tb_uart_loader;
  localparam int ADDR_W  = 4;
  localparam int TIMEOUT = 40;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  uart_loader_if #(.ADDR_W(ADDR_W)) bus();

  uart_loader #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [87:0] bytes;
    int          nb;
    int          nwr;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [7:0]  reply;
    int          starts;
  } vec_t;

  vec_t tv[6];

  logic [7:0]  rxq[$];
  logic [7:0]  rep_q[$];
  int          rcyc_q[$];
  int          wa_q[$];
  logic [31:0] wd_q[$];
  int          wcyc_q[$];
  int          pcyc_q[$];
  int          cyc    = 0;
  int          starts = 0;
  int          viol   = 0;
  int          n_vec  = 0;
  int          n_bad  = 0;
  bit          ok;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  function automatic logic [31:0] outs_or();
    return 32'({bus.rd, bus.wr, bus.w_data, bus.imem_we, bus.cpu_start, bus.busy})
         | 32'(bus.imem_addr) | bus.imem_wdata;
  endfunction

  task automatic drive_rx();
    bus.rd_empty = (rxq.size() == 0);
    bus.r_data   = (rxq.size() == 0) ? 8'h00 : rxq[0];
  endtask

  task automatic clear_logs();
    rep_q.delete(); rcyc_q.delete(); wa_q.delete(); wd_q.delete();
    wcyc_q.delete(); pcyc_q.delete();
    starts = 0;
    viol   = 0;
  endtask

  // Sample outputs mid-cycle, then advance one clock and retire any popped byte.
  task automatic step();
    logic popped;
    @(negedge clk);
    if (bus.rd && bus.rd_empty)      viol++;
    if (bus.cpu_start && bus.imem_we) viol++;
    if (bus.wr && bus.wr_full)       viol++;
    popped = bus.rd && !bus.rd_empty;
    if (popped) pcyc_q.push_back(cyc);
    if (bus.imem_we) begin
      wa_q.push_back(int'(bus.imem_addr));
      wd_q.push_back(bus.imem_wdata);
      wcyc_q.push_back(cyc);
    end
    if (bus.cpu_start) starts++;
    if (bus.wr) begin
      rep_q.push_back(bus.w_data);
      rcyc_q.push_back(cyc);
    end
    @(posedge clk);
    #1;
    cyc++;
    if (popped) void'(rxq.pop_front());
    drive_rx();
  endtask

  task automatic wait_reply(input int n, input int bound, output bit done);
    done = 1'b0;
    for (int i = 0; i < bound && !done; i++) begin
      step();
      if (rep_q.size() >= n) done = 1'b1;
    end
  endtask

  task automatic push_bytes(input logic [87:0] b, input int nb);
    for (int j = 0; j < nb; j++) rxq.push_back(b[87-8*j -: 8]);
    drive_rx();
  endtask

  initial begin
    bus.rd_empty = 1'b1;
    bus.r_data   = 8'h00;
    bus.wr_full  = 1'b0;

    tv[0] = '{88'hA5_02_00_78_56_34_12_EF_BE_AD_DE, 11, 2, 32'h12345678, 32'hDEADBEEF, 8'h06, 0};
    tv[1] = '{{8'h5A, 80'h0},                         1, 0, 32'h0,        32'h0,        8'h06, 1};
    tv[2] = '{{8'h3C, 80'h0},                         1, 0, 32'h0,        32'h0,        8'h15, 0};
    tv[3] = '{{24'hA5_11_00, 64'h0},                  3, 0, 32'h0,        32'h0,        8'h15, 0};
    tv[4] = '{{24'hA5_00_00, 64'h0},                  3, 0, 32'h0,        32'h0,        8'h06, 0};
    tv[5] = '{{56'hA5_01_00_44_33_22_11, 32'h0},      7, 1, 32'h11223344, 32'h0,        8'h06, 0};

    // Reset and idle state
    repeat (3) step();
    chk("reset_outputs", outs_or(), 32'h0);
    reset = 1'b1;
    repeat (5) step();
    chk("idle_outputs", outs_or(), 32'h0);
    chk("idle_no_pop", 32'(pcyc_q.size()), 32'd0);

    // Table-driven commands
    for (int i = 0; i < 6; i++) begin
      clear_logs();
      push_bytes(tv[i].bytes, tv[i].nb);
      wait_reply(1, 400, ok);
      chk($sformatf("v%0d_done", i), 32'(ok), 32'd1);
      repeat (4) step();
      chk($sformatf("v%0d_nreply", i), 32'(rep_q.size()), 32'd1);
      if (rep_q.size() > 0) chk($sformatf("v%0d_reply", i), 32'(rep_q[0]), 32'(tv[i].reply));
      chk($sformatf("v%0d_nwrites", i), 32'(wa_q.size()), 32'(tv[i].nwr));
      chk($sformatf("v%0d_starts", i), 32'(starts), 32'(tv[i].starts));
      chk($sformatf("v%0d_busy", i), 32'(bus.busy), 32'd0);
      chk($sformatf("v%0d_viol", i), 32'(viol), 32'd0);
      if (tv[i].nwr >= 1 && wa_q.size() >= 1 && pcyc_q.size() >= 7) begin
        chk($sformatf("v%0d_addr0", i), 32'(wa_q[0]), 32'd0);
        chk($sformatf("v%0d_data0", i), wd_q[0], tv[i].d0);
        chk($sformatf("v%0d_lat0", i), 32'(wcyc_q[0] - pcyc_q[6]), 32'd1);
      end
      if (tv[i].nwr >= 2 && wa_q.size() >= 2 && pcyc_q.size() >= 11) begin
        chk($sformatf("v%0d_addr1", i), 32'(wa_q[1]), 32'd1);
        chk($sformatf("v%0d_data1", i), wd_q[1], tv[i].d1);
        chk($sformatf("v%0d_lat1", i), 32'(wcyc_q[1] - pcyc_q[10]), 32'd1);
      end
    end

    // RUN with the transmit FIFO full for 10 cycles
    clear_logs();
    bus.wr_full = 1'b1;
    push_bytes({8'h5A, 80'h0}, 1);
    repeat (10) step();
    chk("full_starts", 32'(starts), 32'd1);
    chk("full_no_push", 32'(rep_q.size()), 32'd0);
    chk("full_busy", 32'(bus.busy), 32'd1);
    bus.wr_full = 1'b0;
    wait_reply(1, 20, ok);
    repeat (3) step();
    chk("full_nreply", 32'(rep_q.size()), 32'd1);
    if (rep_q.size() > 0) chk("full_reply", 32'(rep_q[0]), 32'h06);
    chk("full_viol", 32'(viol), 32'd0);

    // Inter-byte timeout inside the payload
    clear_logs();
    push_bytes({40'hA5_01_00_11_22, 48'h0}, 5);
    wait_reply(1, 200, ok);
    chk("tmo_done", 32'(ok), 32'd1);
    chk("tmo_nwrites", 32'(wa_q.size()), 32'd0);
    if (rep_q.size() > 0 && pcyc_q.size() >= 5) begin
      chk("tmo_reply", 32'(rep_q[0]), 32'h15);
      chk("tmo_gap", 32'(rcyc_q[0] - pcyc_q[4]), 32'(TIMEOUT + 1));
    end
    repeat (2) step();
    chk("tmo_idle", 32'(bus.busy), 32'd0);

    // Byte after a NAK is a fresh command
    clear_logs();
    push_bytes({16'h3C_5A, 72'h0}, 2);
    wait_reply(2, 50, ok);
    chk("nak_run_done", 32'(ok), 32'd1);
    if (rep_q.size() >= 2) chk("nak_run_replies", {16'h0, rep_q[0], rep_q[1]}, 32'h0000_1506);
    chk("nak_run_starts", 32'(starts), 32'd1);

    // Full-depth load: N = 2^ADDR_W
    clear_logs();
    push_bytes({24'hA5_10_00, 64'h0}, 3);
    for (int k = 0; k < 64; k++) rxq.push_back(8'(k));
    drive_rx();
    wait_reply(1, 600, ok);
    chk("full_load_done", 32'(ok), 32'd1);
    chk("full_load_nwrites", 32'(wa_q.size()), 32'd16);
    for (int k = 0; k < 16 && k < wa_q.size(); k++) begin
      chk($sformatf("full_load_addr%0d", k), 32'(wa_q[k]), 32'(k));
      chk($sformatf("full_load_data%0d", k), wd_q[k],
          {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)});
    end
    if (rep_q.size() > 0) chk("full_load_reply", 32'(rep_q[0]), 32'h06);

    // Reset in the middle of a 2-word load
    clear_logs();
    push_bytes(88'hA5_02_00_01_02_03_04_05_06_00_00, 9);
    for (int i = 0; i < 60 && pcyc_q.size() < 9; i++) step();
    chk("mid_pops", 32'(pcyc_q.size()), 32'd9);
    chk("mid_nwrites", 32'(wa_q.size()), 32'd1);
    rxq.push_back(8'h5A);
    drive_rx();
    #2;
    reset = 1'b0;
    #1;
    chk("mid_reset_outputs", outs_or(), 32'h0);
    rxq.delete();
    drive_rx();
    repeat (3) step();
    reset = 1'b1;
    repeat (20) step();
    chk("mid_no_reply", 32'(rep_q.size()), 32'd0);
    chk("mid_nwrites_after", 32'(wa_q.size()), 32'd1);
    chk("mid_busy", 32'(bus.busy), 32'd0);
    chk("mid_viol", 32'(viol), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/uart_loader.md
Name: uart_loader

Overview:
- Command/program loader sitting directly downstream of the UART's receive FIFO; it also drives the UART's transmit FIFO for replies.
- Pops received bytes and parses a simple command protocol.
- Assembles little-endian 32-bit words and writes them sequentially into instruction memory from address 0.
- Pulses a CPU start strobe on command, and returns an ACK/NAK byte for every command.

Parameters:
- ADDR_W, 10, instruction memory word-address width. Capacity is 2^ADDR_W words.
- TIMEOUT, 50000, maximum clk cycles allowed between consecutive bytes inside a command before it is aborted.
- ACK_BYTE, 8'h06, reply byte on success.
- NAK_BYTE, 8'h15, reply byte on error.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- rd_empty  in  1  receive FIFO empty
- r_data  in  8  receive FIFO head byte; valid whenever rd_empty=0 (first-word fall-through)
- rd  out  1  pop receive FIFO
- wr_full  in  1  transmit FIFO full
- wr  out  1  push w_data into transmit FIFO
- w_data  out  8  reply byte
- imem_we  out  1  instruction memory write enable
- imem_addr  out  ADDR_W  instruction memory word address
- imem_wdata  out  32  instruction memory write data
- cpu_start  out  1  one-cycle start pulse to the CPU
- busy  out  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE.
  - All outputs are 0: rd, wr, w_data, imem_we, imem_addr, imem_wdata, cpu_start, busy.
  - Internal counters are cleared.
- Byte intake:
  - rd is asserted for exactly one cycle only when rd_empty=0 and the current state accepts a byte.
  - The byte is captured from r_data in that same cycle.
  - At most one pop per cycle. Never pop when rd_empty=1.
- Commands (first byte in IDLE):
  - 8'hA5 = LOAD: followed by N_lo, N_hi (16-bit word count N), then 4*N payload bytes, LSB first per word.
  - 8'h5A = RUN.
  - Any other byte: go to NAK.
- FSM states: IDLE, CNT_LO, CNT_HI, CHECK, PAYLOAD, WRITE, RUN, ACK, NAK.
  - IDLE: pop a byte; A5 goes to CNT_LO, 5A goes to RUN, anything else goes to NAK.
  - CNT_LO / CNT_HI: pop the count bytes, then go to CHECK.
  - CHECK (1 cycle):
    - N=0 goes to ACK.
    - N>2^ADDR_W goes to NAK, with no memory writes.
    - Otherwise clear the word index to 0 and the byte index to 0, then go to PAYLOAD.
  - PAYLOAD: pop bytes into the byte lanes [7:0], [15:8], [23:16], [31:24] in order. After the 4th byte, go to WRITE.
  - WRITE (1 cycle):
    - imem_we=1, imem_addr=word index, imem_wdata=assembled word.
    - Increment the word index.
    - If word index+1==N go to ACK, else return to PAYLOAD.
    - Latency: imem_we rises the cycle after the 4th byte of each word is popped.
  - RUN: cpu_start=1 for exactly one cycle, then go to ACK. No memory writes.
  - ACK / NAK:
    - Wait while wr_full=1.
    - When wr_full=0, assert wr for one cycle with w_data=ACK_BYTE or NAK_BYTE respectively.
    - Then go to IDLE.
    - w_data holds its value after the push.
- Timeout:
  - In CNT_LO, CNT_HI and PAYLOAD, a counter increments each cycle with no pop and clears on each pop.
  - Reaching TIMEOUT goes to NAK. Partially assembled words are discarded and not written.
- Boundaries:
  - N=2^ADDR_W is accepted; the final write is to address 2^ADDR_W-1 with no wrap.
  - IDLE waits indefinitely; there is no timeout in IDLE.
  - cpu_start and imem_we are never asserted in the same cycle.
  - Bytes arriving after a NAK are parsed as new commands.
- Reset mid-load: immediate abort to IDLE, no reply is sent, and memory already written is left as is.

Test Plan:
- Reset, then idle with rd_empty=1 -> all outputs 0, busy=0, rd never asserts.
- Bytes A5,02,00,78,56,34,12,EF,BE,AD,DE -> imem writes addr0=32'h12345678 then addr1=32'hDEADBEEF, each one cycle after its 4th pop; then wr=1 with w_data=06, busy returns to 0.
- Byte 5A with wr_full held 1 for 10 cycles -> cpu_start pulses once; wr stays 0 while full, then exactly one push of 06 after wr_full falls.
- Bytes A5,01,00,11,22 then silence for TIMEOUT cycles -> no imem_we, one push of 15, state IDLE.
- ADDR_W=4, bytes A5,11,00 (N=17) -> NAK 15, no writes. Separately, N=16 with 64 payload bytes -> last write to addr 15, then ACK 06.
- Unknown byte 3C -> NAK 15; reset=0 asserted during PAYLOAD of a 2-word load -> outputs clear immediately and no reply is pushed.
